// File: rtl/tl_ul_client_arbiter.sv
// Round-robin arbiter sharing one TileLink-UL single-beat manager port among
// N_REQ clients, with source tagging, D routing and per-client outstanding limits.
module tl_ul_client_arbiter #(
   parameter int N_REQ     = 2,
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 2,
   localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_a_valid,
   output logic [N_REQ-1:0]          req_a_ready,
   input  logic [3*N_REQ-1:0]        req_a_opcode,
   input  logic [ADDR_W*N_REQ-1:0]   req_a_address,
   input  logic [DATA_W*N_REQ-1:0]   req_a_data,
   output logic [N_REQ-1:0]          req_d_valid,
   input  logic [N_REQ-1:0]          req_d_ready,
   output logic [2:0]                req_d_opcode,
   output logic [DATA_W-1:0]         req_d_data,
   output logic                      req_d_denied,
   output logic                      req_d_corrupt,
   output logic                      out_a_valid,
   input  logic                      out_a_ready,
   output logic [2:0]                out_a_opcode,
   output logic [ADDR_W-1:0]         out_a_address,
   output logic [DATA_W-1:0]         out_a_data,
   output logic [IDX_W-1:0]          out_a_source,
   input  logic                      out_d_valid,
   output logic                      out_d_ready,
   input  logic [2:0]                out_d_opcode,
   input  logic [IDX_W-1:0]          out_d_source,
   input  logic [DATA_W-1:0]         out_d_data,
   input  logic                      out_d_denied,
   input  logic                      out_d_corrupt,
   output logic                      err_bad_source
);

   localparam int CNT_W = (MAX_OUTST > 0) ? $clog2(MAX_OUTST + 1) : 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t              state_r, state_s;
   logic [IDX_W-1:0]    last_r, last_s;
   logic [IDX_W-1:0]    hold_r, hold_s;
   logic [IDX_W-1:0]    win_s, grant_s;
   logic [CNT_W-1:0]    cnt_r [N_REQ];
   logic [CNT_W-1:0]    cnt_s [N_REQ];
   logic                err_r;
   logic [N_REQ-1:0]    elig_s;
   logic [N_REQ-1:0]    a_ready_s;
   logic [N_REQ-1:0]    d_valid_s;
   logic [N_REQ-1:0]    d_fire_s;
   logic                a_valid_s;
   logic                a_fire_s;
   logic                d_ready_s;
   logic                bad_s;
   logic [2:0]          a_op_s;
   logic [ADDR_W-1:0]   a_addr_s;
   logic [DATA_W-1:0]   a_data_s;

   // First eligible index after the last winner, wrapping modulo N_REQ.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] elig,
                                                input logic [IDX_W-1:0] last);
      int  idx;
      logic found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last) + k) % N_REQ;
         if (!found && elig[idx]) begin
            rr_pick = IDX_W'(idx);
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   // Eligibility: valid request and below the outstanding limit.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         elig_s[i] = req_a_valid[i] & (cnt_r[i] < CNT_W'(MAX_OUTST));
      end
   end

   assign win_s = rr_pick(elig_s, last_r);

   // Grant selection and arbitration FSM next state.
   always_comb begin
      state_s   = state_r;
      last_s    = last_r;
      hold_s    = hold_r;
      grant_s   = hold_r;
      a_valid_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            grant_s   = win_s;
            a_valid_s = reset & (|elig_s);
         end
         ST_HOLD: begin
            grant_s   = hold_r;
            a_valid_s = reset & req_a_valid[hold_r];
         end
         default: begin
            grant_s   = hold_r;
            a_valid_s = 1'b0;
         end
      endcase
      a_fire_s = a_valid_s & out_a_ready;
      case (state_r)
         ST_IDLE: begin
            if (a_fire_s) begin
               last_s = grant_s;
            end else if (a_valid_s) begin
               hold_s  = grant_s;
               state_s = ST_HOLD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            // A dropped valid while locked is a client violation; just release.
            if (a_fire_s) begin
               last_s  = hold_r;
               state_s = ST_IDLE;
            end else if (!req_a_valid[hold_r]) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // A payload mux and per-requester ready.
   always_comb begin
      a_op_s    = 3'b000;
      a_addr_s  = {ADDR_W{1'b0}};
      a_data_s  = {DATA_W{1'b0}};
      a_ready_s = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_s == IDX_W'(i)) begin
            a_op_s       = req_a_opcode[3*i +: 3];
            a_addr_s     = req_a_address[ADDR_W*i +: ADDR_W];
            a_data_s     = req_a_data[DATA_W*i +: DATA_W];
            a_ready_s[i] = a_valid_s & out_a_ready;
         end else begin
            a_ready_s[i] = 1'b0;
         end
      end
   end

   // D routing by source; unknown or unmatched sources are sunk.
   always_comb begin
      d_valid_s = {N_REQ{1'b0}};
      d_ready_s = 1'b1;
      bad_s     = out_d_valid;
      for (int i = 0; i < N_REQ; i++) begin
         if (out_d_source == IDX_W'(i)) begin
            if (cnt_r[i] != {CNT_W{1'b0}}) begin
               d_valid_s[i] = out_d_valid;
               d_ready_s    = req_d_ready[i];
               bad_s        = 1'b0;
            end else begin
               d_ready_s    = out_d_valid ? 1'b1 : req_d_ready[i];
            end
         end else begin
            d_valid_s[i] = 1'b0;
         end
      end
   end

   assign d_fire_s = d_valid_s & req_d_ready & {N_REQ{reset}};

   // Outstanding counters; a same-cycle A and D fire cancel out.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         case ({a_fire_s & (grant_s == IDX_W'(i)), d_fire_s[i]})
            2'b10:   cnt_s[i] = cnt_r[i] + CNT_W'(1'b1);
            2'b01:   cnt_s[i] = cnt_r[i] - CNT_W'(1'b1);
            default: cnt_s[i] = cnt_r[i];
         endcase
      end
   end

   // State, counters and sticky error register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         last_r  <= IDX_W'(N_REQ - 1);
         hold_r  <= {IDX_W{1'b0}};
         err_r   <= 1'b0;
         for (int i = 0; i < N_REQ; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         state_r <= state_s;
         last_r  <= last_s;
         hold_r  <= hold_s;
         err_r   <= err_r | bad_s;
         for (int i = 0; i < N_REQ; i++) begin
            cnt_r[i] <= cnt_s[i];
         end
      end
   end

   assign out_a_valid    = a_valid_s;
   assign req_a_ready    = a_ready_s;
   assign out_a_opcode   = a_op_s;
   assign out_a_address  = a_addr_s;
   assign out_a_data     = a_data_s;
   assign out_a_source   = grant_s;
   assign req_d_valid    = d_valid_s & {N_REQ{reset}};
   assign out_d_ready    = d_ready_s & reset;
   assign req_d_opcode   = out_d_opcode;
   assign req_d_data     = out_d_data;
   assign req_d_denied   = out_d_denied;
   assign req_d_corrupt  = out_d_corrupt;
   assign err_bad_source = err_r;

endmodule

// File: doc/tl_ul_client_arbiter.md
Name: tl_ul_client_arbiter

Overview:
- Shares one TileLink-UL single-beat manager port (A request / D response) among N_REQ client requesters.
- Round-robin A-channel arbitration with grant hold while backpressured.
- Tags each request with the requester index as out_a_source and routes D responses back by source.
- Per-requester outstanding-transaction limit. Sits upstream of the crossbar input port, in front of the MMIO/debug decode.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 9, address width.
- DATA_W, 32, data width.
- MAX_OUTST, 2, maximum in-flight requests per requester (1..7).
- IDX_W, derived clog2(N_REQ) (min 1), source tag width.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req_a_valid  in  N_REQ  per-requester A valid
- req_a_ready  out  N_REQ  per-requester A ready
- req_a_opcode  in  3*N_REQ  packed A opcodes, requester i at [3i+2:3i]
- req_a_address  in  ADDR_W*N_REQ  packed A addresses
- req_a_data  in  DATA_W*N_REQ  packed A data
- req_d_valid  out  N_REQ  per-requester D valid
- req_d_ready  in  N_REQ  per-requester D ready
- req_d_opcode  out  3  broadcast D opcode
- req_d_data  out  DATA_W  broadcast D data
- req_d_denied  out  1  broadcast D denied
- req_d_corrupt  out  1  broadcast D corrupt
- out_a_valid  out  1  manager A valid
- out_a_ready  in  1  manager A ready
- out_a_opcode  out  3  selected opcode
- out_a_address  out  ADDR_W  selected address
- out_a_data  out  DATA_W  selected data
- out_a_source  out  IDX_W  winner index
- out_d_valid  in  1  manager D valid
- out_d_ready  out  1  manager D ready
- out_d_opcode  in  3  D opcode
- out_d_source  in  IDX_W  D source tag
- out_d_data  in  DATA_W  D data
- out_d_denied  in  1  D denied
- out_d_corrupt  in  1  D corrupt
- err_bad_source  out  1  sticky: D response with invalid or unmatched source

Behaviour:
- Reset (reset==0 at posedge):
  - cnt[i]=0, state=IDLE, last=N_REQ-1, err_bad_source=0.
  - While reset is low, out_a_valid, req_a_ready, req_d_valid and out_d_ready are forced to 0.
- Eligibility: elig[i] = req_a_valid[i] & (cnt[i] < MAX_OUTST).
- IDLE:
  - Winner w is the first eligible index scanning last+1, last+2, ... modulo N_REQ.
  - Selection is combinational with zero latency: out_a_valid = |elig, and out_a_* carry requester w's fields with out_a_source = w.
  - req_a_ready[w] = out_a_ready; all other req_a_ready bits are 0.
  - Fire (out_a_valid & out_a_ready): last<=w, cnt[w]+=1, stay IDLE.
  - Valid without ready: hold<=w, go to HOLD.
- HOLD:
  - Grant is locked to hold. out_a_valid = req_a_valid[hold]; the outstanding limit is not re-checked.
  - Other requesters are not granted, even if higher priority.
  - Fire: last<=hold, cnt[hold]+=1, go to IDLE.
  - The next grant is evaluated in the following cycle, so there is no back-to-back grant within one cycle.
  - If req_a_valid[hold] drops (client protocol violation), go to IDLE with no count change.
- D routing (combinational):
  - req_d_valid[i] = out_d_valid & (out_d_source==i) & (cnt[i]!=0).
  - out_d_ready = req_d_ready[out_d_source].
  - D payload is broadcast to all requesters unmodified.
- D fire for source s decrements cnt[s].
- Same-cycle A fire and D fire on the same requester: cnt is unchanged.
- Bad source (out_d_source >= N_REQ, or cnt[s]==0 with out_d_valid):
  - out_d_ready=1 and the beat is dropped; no req_d_valid is asserted.
  - err_bad_source<=1, held until reset.
  - cnt is never decremented below 0.
- Counter width is clog2(MAX_OUTST+1). cnt never exceeds MAX_OUTST because eligibility blocks at the limit.
- A and D channels are independent: a D response may complete in the same cycle as the A fire of another request.

Test Plan:
- N_REQ=2, reset released, both req_a_valid=1, out_a_ready=1, 4 cycles, immediate D responses → grants 0,1,0,1 with out_a_source matching; each cnt returns to 0.
- Req0 only valid, out_a_ready=0 for 3 cycles, req1 asserts valid in cycle 2 → out_a_* stays on req0 data/address, req_a_ready[1]=0; on ready, req0 fires; req1 fires in the next cycle.
- MAX_OUTST=2, req0 issues 2 requests with no D → third request is blocked (out_a_valid=0 if req0 is the only requester). D with source=0 accepted → req0 eligible again next cycle.
- D response source=1 with req_d_ready[1]=0 for 2 cycles → out_d_ready=0 and req_d_valid=2'b10 are held; data 0xDEADBEEF is delivered on the ready cycle; cnt[1] decrements once.
- out_d_valid with source=1 while cnt[1]=0 → out_d_ready=1, req_d_valid=0, err_bad_source=1 from the next cycle until reset.
- reset=0 asserted in HOLD with cnt[0]=1 → next cycle state=IDLE, cnt[0]=0, err=0; after release, req0 wins first (last=N_REQ-1).
